// File: rtl/jtag_cmd_ctrl_pkg.sv
// rtl/jtag_cmd_ctrl_pkg.sv - instruction codes and FSM states for the JTAG command controller
package jtag_cmd_ctrl_pkg;

    localparam int IR_LENGTH = 4;

    // TAP instruction codes
    localparam logic [IR_LENGTH-1:0] IIDENT = 4'h1;
    localparam logic [IR_LENGTH-1:0] IRADDR = 4'h2;
    localparam logic [IR_LENGTH-1:0] IWADDR = 4'h3;
    localparam logic [IR_LENGTH-1:0] IWDATA = 4'h4;
    localparam logic [IR_LENGTH-1:0] IRDATA = 4'h5;
    localparam logic [IR_LENGTH-1:0] IFLAGS = 4'h6;

    // Command FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CAPT  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_UPD   = 3'd3,
        ST_WR    = 3'd4
    } state_e;

endpackage

// File: rtl/jtag_cmd_ctrl_sync.sv
// rtl/jtag_cmd_ctrl_sync.sv - 2-FF synchroniser for TAP signals with tck rising-edge detect
module jtag_sync #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         tck_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic         tck_rise_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;
    logic         tck1_q;
    logic         tck2_q;
    logic         tck3_q;

    // Two flop stages on every TAP signal so the bus lines up with the synced tck
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q   <= '0;
            s2_q   <= '0;
            tck1_q <= 1'b0;
            tck2_q <= 1'b0;
            tck3_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            tck1_q <= tck_i;
            tck2_q <= tck1_q;
            tck3_q <= tck2_q;
        end
    end

    assign q_o        = s2_q;
    assign tck_rise_o = tck2_q & ~tck3_q;

endmodule

// File: rtl/jtag_cmd_ctrl.sv
// rtl/jtag_cmd_ctrl.sv - JTAG DR command controller driving sample RAM port and flags
module jtag_cmd_ctrl
    import jtag_cmd_ctrl_pkg::*;
#(
    parameter int          DR_WIDTH = 32,
    parameter int          ADDR_W   = 12,
    parameter int          DATA_W   = 16,
    parameter int          FLAGS_W  = 8,
    parameter logic [31:0] ID_VALUE = 32'h4A544147
) (
    input  logic                 clk_50_,
    input  logic                 reset,
    input  logic                 tck,
    input  logic                 tdi,
    output logic                 tdo,
    input  logic [IR_LENGTH-1:0] ir,
    input  logic                 capture_dr,
    input  logic                 shift_dr,
    input  logic                 update_dr,
    output logic [ADDR_W-1:0]    mem_raddr,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic [ADDR_W-1:0]    mem_waddr,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic                 mem_we,
    output logic [FLAGS_W-1:0]   flags
);

    localparam int SW    = IR_LENGTH + 4;
    localparam int CNT_W = $clog2(DR_WIDTH + 1);

    logic [SW-1:0]        sync_q;
    logic                 tck_rise;
    logic                 tdi_s;
    logic                 cap_s;
    logic                 sh_s;
    logic                 upd_s;
    logic [IR_LENGTH-1:0] ir_s;
    logic                 cap_ev;
    logic                 sh_ev;
    logic                 upd_ev;
    logic                 ir_chg;
    logic [CNT_W-1:0]     shamt;

    state_e               state_q, state_d;
    logic [DR_WIDTH-1:0]  dr_q, dr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IR_LENGTH-1:0] ir_q;
    logic [ADDR_W-1:0]    raddr_q, raddr_d;
    logic [ADDR_W-1:0]    waddr_q, waddr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [FLAGS_W-1:0]   flags_q, flags_d;
    logic                 we_q, we_d;
    logic                 wr_pend_q, wr_pend_d;
    logic                 tdo_q, tdo_d;

    jtag_sync #(
        .W (SW)
    ) u_sync (
        .clk_i      (clk_50_),
        .reset_i    (reset),
        .tck_i      (tck),
        .d_i        ({ir, update_dr, shift_dr, capture_dr, tdi}),
        .q_o        (sync_q),
        .tck_rise_o (tck_rise)
    );

    assign tdi_s = sync_q[0];
    assign cap_s = sync_q[1];
    assign sh_s  = sync_q[2];
    assign upd_s = sync_q[3];
    assign ir_s  = sync_q[SW-1:4];

    // Priority capture > shift > update if the TAP ever shows more than one
    assign cap_ev = tck_rise & cap_s;
    assign sh_ev  = tck_rise & sh_s & ~cap_s;
    assign upd_ev = tck_rise & upd_s & ~cap_s & ~sh_s;
    assign ir_chg = (ir_s != ir_q);

    // The last N bits shifted sit at the top of the DR; this right-aligns them
    assign shamt = CNT_W'(DR_WIDTH) - cnt_q;

    // FSM state register
    always_ff @(posedge clk_50_) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; an IR change or capture restarts the command
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:          ;
            ST_CAPT, ST_SHIFT: if (sh_ev) state_d = ST_SHIFT;
            ST_UPD:           state_d = wr_pend_q ? ST_WR : ST_IDLE;
            ST_WR:            state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase
        if (upd_ev) begin
            state_d = ST_UPD;
        end
        if (cap_ev || ir_chg) begin
            state_d = ST_CAPT;
        end
    end

    // Datapath next state: DR capture/shift, update actions, write strobe and address bump
    always_comb begin
        dr_d      = dr_q;
        cnt_d     = cnt_q;
        raddr_d   = raddr_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        flags_d   = flags_q;
        wr_pend_d = 1'b0;
        we_d      = (state_q == ST_UPD) && wr_pend_q;
        tdo_d     = dr_q[0];

        // Write address advances on the cycle after the strobe
        if (we_q) begin
            waddr_d = waddr_q + ADDR_W'(1);
        end

        if (cap_ev) begin
            cnt_d = '0;
            case (ir_s)
                IIDENT:  dr_d = DR_WIDTH'(ID_VALUE);
                IRDATA:  dr_d = DR_WIDTH'(mem_rdata);
                IRADDR:  dr_d = DR_WIDTH'(raddr_q);
                IWADDR:  dr_d = DR_WIDTH'(waddr_q);
                IFLAGS:  dr_d = DR_WIDTH'(flags_q);
                default: dr_d = '0;
            endcase
        end else if (sh_ev) begin
            dr_d = {tdi_s, dr_q[DR_WIDTH-1:1]};
            if (cnt_q != CNT_W'(DR_WIDTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (upd_ev) begin
            if (ir_s == IRDATA) begin
                // Prefetch the next word for the following capture
                raddr_d = raddr_q + ADDR_W'(1);
            end else if (cnt_q != '0) begin
                case (ir_s)
                    IRADDR: raddr_d = ADDR_W'(dr_q >> shamt);
                    IWADDR: waddr_d = ADDR_W'(dr_q >> shamt);
                    IWDATA: begin
                        // A short shift leaves the RAM untouched
                        if (cnt_q >= CNT_W'(DATA_W)) begin
                            wdata_d   = DATA_W'(dr_q >> shamt);
                            wr_pend_d = 1'b1;
                        end
                    end
                    IFLAGS:  flags_d = FLAGS_W'(dr_q >> shamt);
                    default: ;
                endcase
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_50_) begin
        if (reset) begin
            dr_q      <= '0;
            cnt_q     <= '0;
            ir_q      <= '0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            flags_q   <= '0;
            we_q      <= 1'b0;
            wr_pend_q <= 1'b0;
            tdo_q     <= 1'b0;
        end else begin
            dr_q      <= dr_d;
            cnt_q     <= cnt_d;
            ir_q      <= ir_s;
            raddr_q   <= raddr_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            flags_q   <= flags_d;
            we_q      <= we_d;
            wr_pend_q <= wr_pend_d;
            tdo_q     <= tdo_d;
        end
    end

    assign tdo       = tdo_q;
    assign mem_raddr = raddr_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_jtag_cmd_ctrl.sv
// tb/tb_jtag_cmd_ctrl.sv - self-checking bench for jtag_cmd_ctrl with behavioural TAP-level model
module tb_jtag_cmd_ctrl;
    import jtag_cmd_ctrl_pkg::*;

    logic        clk_50_    = 1'b0;
    logic        reset      = 1'b1;
    logic        tck        = 1'b0;
    logic        tdi        = 1'b0;
    logic [3:0]  ir         = 4'h0;
    logic        capture_dr = 1'b0;
    logic        shift_dr   = 1'b0;
    logic        update_dr  = 1'b0;
    logic        tdo;
    logic [11:0] mem_raddr;
    logic [15:0] mem_rdata;
    logic [11:0] mem_waddr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [7:0]  flags;

    int vectors = 0;
    int errors  = 0;
    bit settled = 1'b0;

    always #10 clk_50_ = ~clk_50_;

    jtag_cmd_ctrl dut (
        .clk_50_    (clk_50_),
        .reset      (reset),
        .tck        (tck),
        .tdi        (tdi),
        .tdo        (tdo),
        .ir         (ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .flags      (flags)
    );

    function automatic logic [15:0] fill_val(input int a);
        logic [31:0] p;
        p = a * 40503;
        return p[15:0] ^ 16'h5A5A;
    endfunction

    // Sample RAM: filled with a known pattern first, then written by the DUT
    logic [15:0] ram [4096];
    int fill_idx = 0;
    always @(posedge clk_50_) begin
        if (fill_idx < 4096) begin
            ram[fill_idx[11:0]] <= fill_val(fill_idx);
            fill_idx <= fill_idx + 1;
        end else if (mem_we) begin
            ram[mem_waddr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_raddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model at TAP-transaction level
    logic [31:0] m_dr;
    int          m_cnt;
    logic [11:0] m_raddr, m_waddr;
    logic [15:0] m_wdata;
    logic [7:0]  m_flags;
    logic [15:0] m_written [int];
    logic [27:0] exp_wq [$];

    function automatic logic [15:0] m_read(input logic [11:0] a);
        if (m_written.exists(int'(a))) return m_written[int'(a)];
        return fill_val(int'(a));
    endfunction

    task automatic model_reset();
        m_dr = '0; m_cnt = 0; m_raddr = '0; m_waddr = '0; m_wdata = '0; m_flags = '0;
    endtask

    task automatic model_event(input bit c, input bit s, input bit u, input bit t);
        logic [31:0] val;
        if (c) begin
            m_cnt = 0;
            if (ir == IIDENT)      m_dr = 32'h4A544147;
            else if (ir == IRDATA) m_dr = {16'h0, m_read(m_raddr)};
            else if (ir == IRADDR) m_dr = {20'h0, m_raddr};
            else if (ir == IWADDR) m_dr = {20'h0, m_waddr};
            else if (ir == IFLAGS) m_dr = {24'h0, m_flags};
            else                   m_dr = '0;
        end else if (s) begin
            m_dr = {t, m_dr[31:1]};
            if (m_cnt < 32) m_cnt++;
        end else if (u) begin
            val = (m_cnt == 0) ? 32'h0 : (m_dr >> (32 - m_cnt));
            if (ir == IRDATA) begin
                m_raddr = m_raddr + 12'd1;
            end else if (m_cnt > 0) begin
                if (ir == IRADDR) m_raddr = val[11:0];
                if (ir == IWADDR) m_waddr = val[11:0];
                if (ir == IFLAGS) m_flags = val[7:0];
                if (ir == IWDATA && m_cnt >= 16) begin
                    m_wdata = val[15:0];
                    m_written[int'(m_waddr)] = val[15:0];
                    exp_wq.push_back({m_waddr, val[15:0]});
                    m_waddr = m_waddr + 12'd1;
                end
            end
        end
    endtask

    // Per-cycle comparison while outputs are settled between tck events
    always @(negedge clk_50_) begin
        if (settled) begin
            chk("tdo", {31'h0, tdo}, {31'h0, m_dr[0]});
            chk("mem_raddr", {20'h0, mem_raddr}, {20'h0, m_raddr});
            chk("mem_waddr", {20'h0, mem_waddr}, {20'h0, m_waddr});
            chk("mem_wdata", {16'h0, mem_wdata}, {16'h0, m_wdata});
            chk("flags", {24'h0, flags}, {24'h0, m_flags});
            chk("writes_pending", exp_wq.size(), 0);
        end
    end

    // Write strobe monitor: single-cycle pulses that match the model's write list
    int          dut_wr  = 0;
    logic        we_prev = 1'b0;
    logic [11:0] last_wa = '0;
    logic [15:0] last_wd = '0;
    always @(negedge clk_50_) begin
        logic [27:0] w;
        if (mem_we) begin
            dut_wr++;
            last_wa = mem_waddr;
            last_wd = mem_wdata;
            chk("we_one_cycle", {31'h0, we_prev}, 32'h0);
            if (exp_wq.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_we: waddr %h wdata %h with no write expected", mem_waddr, mem_wdata);
            end else begin
                w = exp_wq.pop_front();
                chk("write_addr_data", {4'h0, mem_waddr, mem_wdata}, {4'h0, w});
            end
        end
        we_prev = mem_we;
    end

    // One tck period: flags set during low phase, event on the rising edge
    task automatic tck_cycle(input bit c, input bit s, input bit u, input bit t, output logic tdo_b);
        int j;
        j = $urandom_range(0, 6);
        capture_dr = c; shift_dr = s; update_dr = u; tdi = t;
        #(40 + j);
        settled = 1'b1;
        #45;
        tdo_b = tdo;
        #5;
        settled = 1'b0;
        #10;
        tck = 1'b1;
        model_event(c, s, u, t);
        #100;
        tck = 1'b0;
    endtask

    task automatic scan(input logic [3:0] irv, input int nbits, input logic [39:0] din,
                        input bit upd, output logic [39:0] dout);
        logic b;
        dout = '0;
        ir = irv;
        tck_cycle(0, 0, 0, 0, b);
        tck_cycle(1, 0, 0, 0, b);
        for (int i = 0; i < nbits; i++) begin
            tck_cycle(0, 1, 0, din[i], b);
            dout[i] = b;
        end
        if (upd) tck_cycle(0, 0, 1, 0, b);
        tck_cycle(0, 0, 0, 0, b);
    endtask

    initial begin
        logic [39:0] d;
        logic        b;
        int          w0;
        logic [3:0]  ir_tab [8];
        ir_tab = '{IIDENT, IRADDR, IWADDR, IWDATA, IRDATA, IFLAGS, 4'h0, 4'hF};
        model_reset();
        #3;
        repeat (4100) @(posedge clk_50_);
        @(negedge clk_50_);
        chk("rst_tdo", {31'h0, tdo}, 32'h0);
        chk("rst_raddr", {20'h0, mem_raddr}, 32'h0);
        chk("rst_waddr", {20'h0, mem_waddr}, 32'h0);
        chk("rst_wdata", {16'h0, mem_wdata}, 32'h0);
        chk("rst_we", {31'h0, mem_we}, 32'h0);
        chk("rst_flags", {24'h0, flags}, 32'h0);
        reset = 1'b0;
        #7;

        scan(IIDENT, 32, 40'h0, 1'b1, d);
        chk("ident_stream", d[31:0], 32'h4A544147);

        w0 = dut_wr;
        scan(IWADDR, 12, 40'h005, 1'b1, d);
        scan(IWDATA, 16, 40'hE000, 1'b1, d);
        chk("wr_pulses", dut_wr - w0, 1);
        chk("wr_addr", {20'h0, last_wa}, 32'h5);
        chk("wr_data", {16'h0, last_wd}, 32'hE000);
        chk("waddr_inc", {20'h0, mem_waddr}, 32'h6);

        w0 = dut_wr;
        scan(IWDATA, 10, 40'h3FF, 1'b1, d);
        chk("short_no_we", dut_wr - w0, 0);
        chk("short_waddr", {20'h0, mem_waddr}, 32'h6);

        scan(IWADDR, 12, 40'hFFF, 1'b1, d);
        scan(IWDATA, 16, 40'h1234, 1'b1, d);
        chk("waddr_wrap", {20'h0, mem_waddr}, 32'h0);
        scan(IRADDR, 12, 40'hFFF, 1'b1, d);
        scan(IRDATA, 16, 40'h0, 1'b1, d);
        chk("rdata_fff", {16'h0, d[15:0]}, 32'h1234);
        chk("raddr_wrap", {20'h0, mem_raddr}, 32'h0);

        scan(IFLAGS, 8, 40'h01, 1'b1, d);
        chk("flags_set", {24'h0, flags}, 32'h01);
        scan(IFLAGS, 8, 40'h0, 1'b0, d);
        chk("flags_readback", {24'h0, d[7:0]}, 32'h01);

        // Reset in the middle of an IWDATA shift
        w0 = dut_wr;
        ir = IWDATA;
        tck_cycle(0, 0, 0, 0, b);
        tck_cycle(1, 0, 0, 0, b);
        for (int i = 0; i < 8; i++) tck_cycle(0, 1, 0, 1'b1, b);
        @(negedge clk_50_);
        reset = 1'b1;
        @(posedge clk_50_);
        #1;
        chk("midrst_tdo", {31'h0, tdo}, 32'h0);
        chk("midrst_raddr", {20'h0, mem_raddr}, 32'h0);
        chk("midrst_waddr", {20'h0, mem_waddr}, 32'h0);
        chk("midrst_wdata", {16'h0, mem_wdata}, 32'h0);
        chk("midrst_we", {31'h0, mem_we}, 32'h0);
        chk("midrst_flags", {24'h0, flags}, 32'h0);
        model_reset();
        repeat (3) @(posedge clk_50_);
        @(negedge clk_50_);
        reset = 1'b0;
        tck_cycle(0, 0, 0, 0, b);
        tck_cycle(0, 0, 1, 0, b);
        tck_cycle(0, 0, 0, 0, b);
        chk("midrst_no_we", dut_wr - w0, 0);

        // Randomized command traffic against the model
        for (int k = 0; k < 60; k++) begin
            logic [3:0] irv;
            int         n;
            irv = ir_tab[$urandom_range(0, 7)];
            n   = $urandom_range(0, 34);
            scan(irv, n, {$urandom(), $urandom()}, ($urandom_range(0, 3) != 0), d);
        end

        chk("final_pending", exp_wq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
